// File: rtl/wb_arbiter_pkg.sv
// Shared writeback-path types and default sizing for the core.
// Imported by the writeback arbiter, its bus interface and its sub-modules.
package wb_arbiter_pkg;

    localparam int unsigned NUM_FU_DEF     = 32'd4;
    localparam int unsigned NUM_WBPORT_DEF = 32'd2;
    localparam int unsigned ROB_IDX_W      = 32'd6;
    localparam int unsigned IROB_IDX_W     = 32'd4;
    localparam int unsigned IPR_IDX_W      = 32'd7;
    localparam int unsigned XLEN           = 32'd64;

    typedef logic [IPR_IDX_W-1:0] iprIdx_t;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_idx;
        logic [IROB_IDX_W-1:0] irob_idx;
        logic                  use_imm;
        logic                  rd_wen;
        iprIdx_t               iprd_idx;
        logic [XLEN-1:0]       result;
    } comwbInfo_t;

    // Saturating 32-bit accumulate for event counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum_s[31:0];
        end
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: FU completion inputs, writeback and bypass outputs.
// Performance counter signals exist only when WBARB_PERF_EN is defined.
interface wb_arbiter_if
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU     = NUM_FU_DEF,
    parameter int unsigned NUM_WBPORT = NUM_WBPORT_DEF
);
    logic [NUM_FU-1:0]                i_fu_finished;
    comwbInfo_t [NUM_FU-1:0]          i_comwbInfo;
    logic [NUM_FU-1:0]                o_wb_stall;
    logic                             i_wb_block;
    logic [NUM_WBPORT-1:0]            o_wb_vld;
    comwbInfo_t [NUM_WBPORT-1:0]      o_wb_info;
    logic [NUM_WBPORT-1:0]            o_rf_wen;
    logic [NUM_WBPORT-1:0]            o_bypass_vld;
    iprIdx_t [NUM_WBPORT-1:0]         o_bypass_rdIdx;
    logic [NUM_WBPORT-1:0][XLEN-1:0]  o_bypass_data;
`ifdef WBARB_PERF_EN
    logic [31:0]                      o_perf_stall_cycles;
    logic [31:0]                      o_perf_wb_count;
`endif

    modport master (
        output i_fu_finished, i_comwbInfo, i_wb_block,
        input  o_wb_stall, o_wb_vld, o_wb_info, o_rf_wen,
        input  o_bypass_vld, o_bypass_rdIdx, o_bypass_data
`ifdef WBARB_PERF_EN
        , input o_perf_stall_cycles, o_perf_wb_count
`endif
    );

    modport slave (
        input  i_fu_finished, i_comwbInfo, i_wb_block,
        output o_wb_stall, o_wb_vld, o_wb_info, o_rf_wen,
        output o_bypass_vld, o_bypass_rdIdx, o_bypass_data
`ifdef WBARB_PERF_EN
        , output o_perf_stall_cycles, o_perf_wb_count
`endif
    );

endinterface

// File: rtl/wb_arbiter_rr_picker.sv
// Round-robin first-K selector: scans requests starting at ptr (wrapping) and
// grants up to NUM_WBPORT of them, reporting per-port FU index and next pointer.
module wb_arbiter_rr_picker #(
    parameter  int unsigned NUM_FU     = 32'd4,
    parameter  int unsigned NUM_WBPORT = 32'd2,
    localparam int unsigned PTR_W      = $clog2(NUM_FU),
    localparam int unsigned CNT_W      = $clog2(NUM_WBPORT + 32'd1)
) (
    input  logic                              en,
    input  logic [NUM_FU-1:0]                 req,
    input  logic [PTR_W-1:0]                  ptr,
    output logic [NUM_FU-1:0]                 gnt,
    output logic [NUM_WBPORT-1:0]             port_vld,
    output logic [NUM_WBPORT-1:0][PTR_W-1:0]  port_idx,
    output logic [PTR_W-1:0]                  next_ptr
);
    localparam logic [PTR_W:0]   NUM_FU_W     = NUM_FU[PTR_W:0];
    localparam logic [CNT_W-1:0] NUM_WBPORT_W = NUM_WBPORT[CNT_W-1:0];
    localparam logic [PTR_W:0]   ONE_P        = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ONE_C        = {{(CNT_W){1'b0}}, 1'b1} | {CNT_W{1'b0}};

    logic [PTR_W:0]   pos_s;
    logic [PTR_W:0]   nxt_s;
    logic [PTR_W-1:0] idx_s;
    logic [CNT_W-1:0] cnt_s;

    // Visit FU (ptr + k) mod NUM_FU for k = 0..NUM_FU-1; earlier visits take lower ports.
    always_comb begin
        gnt      = '0;
        port_vld = '0;
        port_idx = '0;
        next_ptr = ptr;
        cnt_s    = '0;
        pos_s    = '0;
        nxt_s    = '0;
        idx_s    = '0;
        for (int unsigned k = 32'd0; k < NUM_FU; k++) begin
            pos_s = {1'b0, ptr} + k[PTR_W:0];
            if (pos_s >= NUM_FU_W) begin
                pos_s = pos_s - NUM_FU_W;
            end else begin
                pos_s = pos_s;
            end
            idx_s = pos_s[PTR_W-1:0];
            if (en && req[idx_s] && (cnt_s < NUM_WBPORT_W)) begin
                gnt[idx_s] = 1'b1;
                for (int unsigned p = 32'd0; p < NUM_WBPORT; p++) begin
                    if (cnt_s == p[CNT_W-1:0]) begin
                        port_vld[p] = 1'b1;
                        port_idx[p] = idx_s;
                    end else begin
                        port_vld[p] = port_vld[p];
                        port_idx[p] = port_idx[p];
                    end
                end
                nxt_s = {1'b0, idx_s} + ONE_P;
                if (nxt_s >= NUM_FU_W) begin
                    next_ptr = '0;
                end else begin
                    next_ptr = nxt_s[PTR_W-1:0];
                end
                cnt_s = cnt_s + ONE_C;
            end else begin
                cnt_s = cnt_s;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin grants of finished FU results onto NUM_WBPORT
// registered writeback ports with same-cycle bypass. WBARB_PERF_EN adds perf counters.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU     = NUM_FU_DEF,
    parameter int unsigned NUM_WBPORT = NUM_WBPORT_DEF
) (
    input logic         clk,
    input logic         rst,
    wb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(NUM_FU);

    logic                             pick_en_s;
    logic [NUM_FU-1:0]                gnt_s;
    logic [NUM_FU-1:0]                stall_s;
    logic [NUM_WBPORT-1:0]            port_vld_s;
    logic [NUM_WBPORT-1:0][PTR_W-1:0] port_idx_s;
    logic [PTR_W-1:0]                 next_ptr_s;
    comwbInfo_t [NUM_WBPORT-1:0]      sel_info_s;
    logic [PTR_W-1:0]                 rr_ptr_r;
    logic [NUM_WBPORT-1:0]            wb_vld_r;
    comwbInfo_t [NUM_WBPORT-1:0]      wb_info_r;

    // Reset and downstream back-pressure both suppress every grant.
    assign pick_en_s = rst & ~bus.i_wb_block;

    wb_arbiter_rr_picker #(
        .NUM_FU     (NUM_FU),
        .NUM_WBPORT (NUM_WBPORT)
    ) u_picker (
        .en       (pick_en_s),
        .req      (bus.i_fu_finished),
        .ptr      (rr_ptr_r),
        .gnt      (gnt_s),
        .port_vld (port_vld_s),
        .port_idx (port_idx_s),
        .next_ptr (next_ptr_s)
    );

    assign stall_s        = bus.i_fu_finished & ~gnt_s;
    assign bus.o_wb_stall = stall_s;
    assign bus.o_wb_vld   = wb_vld_r;
    assign bus.o_wb_info  = wb_info_r;

    // Route each port's granted payload and form the same-cycle bypass.
    always_comb begin
        sel_info_s         = '0;
        bus.o_bypass_vld   = '0;
        bus.o_bypass_rdIdx = '0;
        bus.o_bypass_data  = '0;
        for (int unsigned p = 32'd0; p < NUM_WBPORT; p++) begin
            sel_info_s[p]         = bus.i_comwbInfo[port_idx_s[p]];
            bus.o_bypass_vld[p]   = port_vld_s[p] & sel_info_s[p].rd_wen;
            bus.o_bypass_rdIdx[p] = sel_info_s[p].iprd_idx;
            bus.o_bypass_data[p]  = sel_info_s[p].result;
        end
    end

    // Regfile write enable per registered port.
    always_comb begin
        bus.o_rf_wen = '0;
        for (int unsigned p = 32'd0; p < NUM_WBPORT; p++) begin
            bus.o_rf_wen[p] = wb_vld_r[p] & wb_info_r[p].rd_wen;
        end
    end

    // Writeback stage register; pointer moves past the last granted FU.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_vld_r  <= '0;
            wb_info_r <= '0;
            rr_ptr_r  <= '0;
        end else begin
            wb_vld_r  <= port_vld_s;
            wb_info_r <= sel_info_s;
            if (port_vld_s[0]) begin
                rr_ptr_r <= next_ptr_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

`ifdef WBARB_PERF_EN
    logic [31:0] n_gnt_s;
    logic [31:0] perf_stall_r;
    logic [31:0] perf_wb_r;

    // Number of grants issued this cycle.
    always_comb begin
        n_gnt_s = 32'd0;
        for (int unsigned p = 32'd0; p < NUM_WBPORT; p++) begin
            n_gnt_s = n_gnt_s + {31'd0, port_vld_s[p]};
        end
    end

    // Saturating stall-cycle and writeback counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_r <= 32'd0;
            perf_wb_r    <= 32'd0;
        end else begin
            perf_stall_r <= sat_add32(perf_stall_r, {31'd0, |stall_s});
            perf_wb_r    <= sat_add32(perf_wb_r, n_gnt_s);
        end
    end

    assign bus.o_perf_stall_cycles = perf_stall_r;
    assign bus.o_perf_wb_count     = perf_wb_r;
`else
    // Base build carries no counter state.
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized FU traffic against a
// queue-based grant reference. Counter scenario is built only with WBARB_PERF_EN.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NF    = 4;
    localparam int NWB   = 2;
    localparam int SLACK = (NF + NWB - 1) / NWB - 1;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   m_ptr;
    int   exp_fu[$];

    wb_arbiter_if #(.NUM_FU(NF), .NUM_WBPORT(NWB)) bus ();

    wb_arbiter #(.NUM_FU(NF), .NUM_WBPORT(NWB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input logic [NF-1:0] fin, input logic blk);
        @(negedge clk);
        bus.i_fu_finished = fin;
        bus.i_wb_block    = blk;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_fu(input int i, input logic wen, input iprIdx_t rd, input logic [63:0] data);
        bus.i_comwbInfo[i].rob_idx  = 6'(i);
        bus.i_comwbInfo[i].irob_idx = 4'(i);
        bus.i_comwbInfo[i].use_imm  = 1'b0;
        bus.i_comwbInfo[i].rd_wen   = wen;
        bus.i_comwbInfo[i].iprd_idx = rd;
        bus.i_comwbInfo[i].result   = data;
    endtask

    // Reference: list FUs in rotated order from m_ptr, keep finished ones, first NWB win.
    function automatic void ref_grant(input logic [NF-1:0] fin, input logic blk);
        exp_fu.delete();
        if (!blk) begin
            for (int k = 0; k < NF; k++) begin
                if (fin[(m_ptr + k) % NF] && exp_fu.size() < NWB) exp_fu.push_back((m_ptr + k) % NF);
            end
        end
        if (exp_fu.size() > 0) m_ptr = (exp_fu[exp_fu.size() - 1] + 1) % NF;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < NF; i++) set_fu(i, 1'b1, iprIdx_t'(i), 64'(i));
        drive(4'b1010, 1'b0);
        checks++;
        if (bus.o_wb_stall !== 4'b1010) begin errors++; $display("FAIL reset_stall: got %b want %b", bus.o_wb_stall, 4'b1010); end
        checks++;
        if (bus.o_bypass_vld !== 2'b00) begin errors++; $display("FAIL reset_bypass: got %b want 00", bus.o_bypass_vld); end
        tick();
        checks++;
        if (bus.o_wb_vld !== 2'b00) begin errors++; $display("FAIL reset_wb_vld: got %b want 00", bus.o_wb_vld); end
        checks++;
        if (bus.o_rf_wen !== 2'b00) begin errors++; $display("FAIL reset_rf_wen: got %b want 00", bus.o_rf_wen); end
        @(negedge clk);
        rst = 1'b1;
        bus.i_fu_finished = '0;
        m_ptr = 0;
    endtask

    task automatic test_grant_all();
        for (int i = 0; i < NF; i++) set_fu(i, 1'b1, iprIdx_t'(i + 1), 64'hA0 + 64'(i));
        drive(4'b1111, 1'b0);
        checks++;
        if (bus.o_wb_stall !== 4'b1100) begin errors++; $display("FAIL grant1_stall: got %b want 1100", bus.o_wb_stall); end
        checks++;
        if ({bus.o_bypass_data[1], bus.o_bypass_data[0]} !== {64'hA1, 64'hA0})
            begin errors++; $display("FAIL grant1_bypass: got %h %h want a1 a0", bus.o_bypass_data[1], bus.o_bypass_data[0]); end
        tick();
        checks++;
        if (bus.o_wb_vld !== 2'b11 || {bus.o_wb_info[1].result, bus.o_wb_info[0].result} !== {64'hA1, 64'hA0})
            begin errors++; $display("FAIL grant1_wb: vld %b data %h %h want 11 a1 a0", bus.o_wb_vld, bus.o_wb_info[1].result, bus.o_wb_info[0].result); end
        drive(4'b1111, 1'b0);
        checks++;
        if (bus.o_wb_stall !== 4'b0011) begin errors++; $display("FAIL grant2_stall: got %b want 0011", bus.o_wb_stall); end
        tick();
        checks++;
        if (bus.o_wb_vld !== 2'b11 || {bus.o_wb_info[1].result, bus.o_wb_info[0].result} !== {64'hA3, 64'hA2})
            begin errors++; $display("FAIL grant2_wb: vld %b data %h %h want 11 a3 a2", bus.o_wb_vld, bus.o_wb_info[1].result, bus.o_wb_info[0].result); end
        drive(4'b0000, 1'b0);
        tick();
        checks++;
        if (bus.o_wb_vld !== 2'b00) begin errors++; $display("FAIL idle_wb_vld: got %b want 00", bus.o_wb_vld); end
        m_ptr = 0;
    endtask

    task automatic test_bypass();
        for (int i = 0; i < NF; i++) set_fu(i, 1'b0, '0, 64'h0);
        set_fu(2, 1'b1, iprIdx_t'(9), 64'h55);
        drive(4'b0100, 1'b0);
        checks++;
        if (bus.o_bypass_vld !== 2'b01 || bus.o_bypass_rdIdx[0] !== iprIdx_t'(9) || bus.o_bypass_data[0] !== 64'h55)
            begin errors++; $display("FAIL bypass: vld %b rd %0d data %h want 01 9 55", bus.o_bypass_vld, bus.o_bypass_rdIdx[0], bus.o_bypass_data[0]); end
        checks++;
        if (bus.o_wb_stall !== 4'b0000) begin errors++; $display("FAIL bypass_stall: got %b want 0000", bus.o_wb_stall); end
        tick();
        checks++;
        if (bus.o_rf_wen !== 2'b01 || bus.o_wb_info[0].result !== 64'h55)
            begin errors++; $display("FAIL bypass_wb: rf_wen %b data %h want 01 55", bus.o_rf_wen, bus.o_wb_info[0].result); end
        drive(4'b0000, 1'b0);
        tick();
        m_ptr = 3;
    endtask

    task automatic test_block();
        for (int i = 0; i < NF; i++) set_fu(i, 1'b1, iprIdx_t'(i), 64'hB0 + 64'(i));
        drive(4'b0011, 1'b1);
        checks++;
        if (bus.o_wb_stall !== 4'b0011 || bus.o_bypass_vld !== 2'b00)
            begin errors++; $display("FAIL block: stall %b bypass %b want 0011 00", bus.o_wb_stall, bus.o_bypass_vld); end
        tick();
        checks++;
        if (bus.o_wb_vld !== 2'b00) begin errors++; $display("FAIL block_wb_vld: got %b want 00", bus.o_wb_vld); end
        drive(4'b1011, 1'b0);
        checks++;
        if (bus.o_wb_stall !== 4'b0010 || {bus.o_bypass_data[1], bus.o_bypass_data[0]} !== {64'hB0, 64'hB3})
            begin errors++; $display("FAIL block_ptr_kept: stall %b data %h %h want 0010 b0 b3", bus.o_wb_stall, bus.o_bypass_data[1], bus.o_bypass_data[0]); end
        tick();
        drive(4'b0000, 1'b0);
        tick();
        m_ptr = 1;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < NF; i++) set_fu(i, 1'b1, iprIdx_t'(i), 64'hC0 + 64'(i));
        drive(4'b1111, 1'b0);
        tick();
        checks++;
        if (bus.o_wb_vld !== 2'b11 || {bus.o_wb_info[1].result, bus.o_wb_info[0].result} !== {64'hC2, 64'hC1})
            begin errors++; $display("FAIL pre_reset_wb: vld %b data %h %h want 11 c2 c1", bus.o_wb_vld, bus.o_wb_info[1].result, bus.o_wb_info[0].result); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.o_wb_stall !== 4'b1111) begin errors++; $display("FAIL mid_reset_stall: got %b want 1111", bus.o_wb_stall); end
        tick();
        checks++;
        if (bus.o_wb_vld !== 2'b00 || bus.o_wb_info[0].rd_wen !== 1'b0 || bus.o_wb_info[1].rd_wen !== 1'b0)
            begin errors++; $display("FAIL mid_reset_wb: vld %b rd_wen %b%b want 00 00", bus.o_wb_vld, bus.o_wb_info[1].rd_wen, bus.o_wb_info[0].rd_wen); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.o_wb_stall !== 4'b1100 || {bus.o_bypass_data[1], bus.o_bypass_data[0]} !== {64'hC1, 64'hC0})
            begin errors++; $display("FAIL post_reset_grant: stall %b data %h %h want 1100 c1 c0", bus.o_wb_stall, bus.o_bypass_data[1], bus.o_bypass_data[0]); end
        tick();
        drive(4'b0000, 1'b0);
        tick();
        m_ptr = 2;
    endtask

    task automatic test_random();
        logic [NF-1:0] pend;
        logic [NF-1:0] gmask;
        logic          blk;
        logic [63:0]   fu_data [NF];
        logic          fu_wen [NF];
        iprIdx_t       fu_rd [NF];
        int            wait_c [NF];
        logic [63:0]   exp_data [NWB];
        logic          exp_wen [NWB];
        int            seen [logic [63:0]];
        int            n_exp;
        int            tag;
        int            issued;
        int            written;
        int            left;
        logic          ev;
        pend = '0;
        tag = 0;
        issued = 0;
        written = 0;
        for (int i = 0; i < NF; i++) wait_c[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < NF; i++) begin
                if (!pend[i] && $urandom_range(0, 9) < 6) begin
                    tag++;
                    issued++;
                    pend[i]    = 1'b1;
                    wait_c[i]  = 0;
                    fu_data[i] = {32'hC0DE0000, 32'(tag)};
                    fu_wen[i]  = 1'($urandom_range(0, 1));
                    fu_rd[i]   = iprIdx_t'($urandom);
                    set_fu(i, fu_wen[i], fu_rd[i], fu_data[i]);
                end
            end
            blk = ($urandom_range(0, 99) < 15);
            drive(pend, blk);
            ref_grant(pend, blk);
            n_exp = exp_fu.size();
            gmask = '0;
            for (int p = 0; p < n_exp; p++) gmask[exp_fu[p]] = 1'b1;
            checks++;
            if (bus.o_wb_stall !== (pend & ~gmask))
                begin errors++; $display("FAIL rnd_stall cyc %0d: got %b want %b", cyc, bus.o_wb_stall, pend & ~gmask); end
            for (int p = 0; p < NWB; p++) begin
                exp_data[p] = (p < n_exp) ? fu_data[exp_fu[p]] : 64'h0;
                exp_wen[p]  = (p < n_exp) ? fu_wen[exp_fu[p]] : 1'b0;
                ev = (p < n_exp) && exp_wen[p];
                checks++;
                if (bus.o_bypass_vld[p] !== ev)
                    begin errors++; $display("FAIL rnd_bypass_vld cyc %0d port %0d: got %b want %b", cyc, p, bus.o_bypass_vld[p], ev); end
                if (ev) begin
                    checks++;
                    if (bus.o_bypass_data[p] !== exp_data[p] || bus.o_bypass_rdIdx[p] !== fu_rd[exp_fu[p]])
                        begin errors++; $display("FAIL rnd_bypass_data cyc %0d port %0d: got %h/%0d want %h/%0d", cyc, p, bus.o_bypass_data[p], bus.o_bypass_rdIdx[p], exp_data[p], fu_rd[exp_fu[p]]); end
                end
            end
            tick();
            for (int p = 0; p < NWB; p++) begin
                ev = (p < n_exp);
                checks++;
                if (bus.o_wb_vld[p] !== ev || bus.o_rf_wen[p] !== (ev & exp_wen[p]))
                    begin errors++; $display("FAIL rnd_wb_vld cyc %0d port %0d: vld %b rf %b want %b %b", cyc, p, bus.o_wb_vld[p], bus.o_rf_wen[p], ev, ev & exp_wen[p]); end
                if (ev) begin
                    checks++;
                    if (bus.o_wb_info[p].result !== exp_data[p])
                        begin errors++; $display("FAIL rnd_wb_data cyc %0d port %0d: got %h want %h", cyc, p, bus.o_wb_info[p].result, exp_data[p]); end
                end
                if (bus.o_wb_vld[p] === 1'b1) begin
                    checks++;
                    if (seen.exists(bus.o_wb_info[p].result))
                        begin errors++; $display("FAIL rnd_duplicate cyc %0d: result %h written again", cyc, bus.o_wb_info[p].result); end
                    seen[bus.o_wb_info[p].result] = 1;
                    written++;
                end
            end
            for (int i = 0; i < NF; i++) begin
                if (gmask[i]) begin
                    checks++;
                    if (wait_c[i] > SLACK)
                        begin errors++; $display("FAIL rnd_starve fu %0d: waited %0d want <= %0d", i, wait_c[i], SLACK); end
                    pend[i] = 1'b0;
                end else if (pend[i] && !blk) begin
                    wait_c[i]++;
                end
            end
        end
        left = 0;
        for (int i = 0; i < NF; i++) left += int'(pend[i]);
        checks++;
        if (written != issued - left)
            begin errors++; $display("FAIL rnd_total: written %0d want %0d", written, issued - left); end
        drive(4'b0000, 1'b0);
        tick();
    endtask

`ifdef WBARB_PERF_EN
    task automatic test_perf();
        @(negedge clk);
        rst = 1'b0;
        bus.i_fu_finished = '0;
        bus.i_wb_block = 1'b0;
        tick();
        checks++;
        if (bus.o_perf_wb_count !== 32'd0 || bus.o_perf_stall_cycles !== 32'd0)
            begin errors++; $display("FAIL perf_reset: wb %0d stall %0d want 0 0", bus.o_perf_wb_count, bus.o_perf_stall_cycles); end
        @(negedge clk);
        rst = 1'b1;
        bus.i_fu_finished = 4'b1111;
        repeat (10) tick();
        checks++;
        if (bus.o_perf_wb_count !== 32'd20 || bus.o_perf_stall_cycles !== 32'd10)
            begin errors++; $display("FAIL perf_count: wb %0d stall %0d want 20 10", bus.o_perf_wb_count, bus.o_perf_stall_cycles); end
        drive(4'b0000, 1'b0);
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        m_ptr  = 0;
        rst    = 1'b0;
        bus.i_fu_finished = '0;
        bus.i_wb_block    = 1'b0;
        bus.i_comwbInfo   = '0;
        test_reset();
        test_grant_all();
        test_bypass();
        test_block();
        test_reset_mid();
        test_random();
`ifdef WBARB_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 4: number of functional-unit completion ports (2..8).
REQ-002 Parameter NUM_WBPORT, default 2: number of writeback ports per cycle (1..NUM_FU).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low (asserted when 0).
REQ-005 i_fu_finished  input  NUM_FU  per-FU result valid; held while that FU's stall is asserted.
REQ-006 i_comwbInfo  input  NUM_FU x comwbInfo_t  per-FU result (rob_idx, irob_idx, use_imm, rd_wen, iprd_idx, result).
REQ-007 o_wb_stall  output  NUM_FU  per-FU stall; FU holds its result and pipeline.
REQ-008 i_wb_block  input  1  downstream (ROB/regfile) cannot accept this cycle.
REQ-009 o_wb_vld  output  NUM_WBPORT  registered writeback valid per port.
REQ-010 o_wb_info  output  NUM_WBPORT x comwbInfo_t  registered writeback payload.
REQ-011 o_rf_wen  output  NUM_WBPORT  regfile write enable = o_wb_vld & o_wb_info.rd_wen.
REQ-012 o_bypass_vld / o_bypass_rdIdx / o_bypass_data  output  NUM_WBPORT x (1 / iprIdx_t / 64)  combinational bypass of this cycle's grants.

Function
REQ-013 Grant: scan FU indices starting at rr_ptr, wrapping modulo NUM_FU; grant the first NUM_WBPORT FUs with i_fu_finished=1; grants map to ports 0,1,... in scan order.
REQ-014 o_wb_stall[i] SHALL be 1 iff i_fu_finished[i]=1 and FU i not granted this cycle; combinational.
REQ-015 i_wb_block=1: no grants; every finished FU stalled; rr_ptr unchanged; o_wb_vld cleared next cycle.
REQ-016 Latency: result granted in cycle T appears on o_wb_vld/o_wb_info at T+1; ungranted port slots give o_wb_vld=0 at T+1.
REQ-017 rr_ptr update: if ≥1 grant, rr_ptr <= (index of last granted FU + 1) mod NUM_FU; else unchanged.
REQ-018 Fewer finished than ports: all granted, zero stalls; no finished FUs: all outputs invalid next cycle.
REQ-019 Bypass: o_bypass_vld[p] = port p granted & rd_wen of granted FU; rdIdx/data from that FU, same cycle as grant.
REQ-020 A stalled FU's result SHALL be granted within ceil(NUM_FU/NUM_WBPORT) non-blocked cycles (starvation-free).
REQ-021 A given FU result SHALL be written back exactly once (no duplicate from a held input after grant).

Reset
REQ-022 While rst=0: o_wb_vld=0, rr_ptr=0, perf counters=0; o_wb_info payload unspecified but rd_wen fields cleared.
REQ-023 o_wb_stall during reset SHALL follow REQ-014 with no grants (all finished FUs stalled).
REQ-024 Reset asserted mid-operation discards registered writebacks; first grant after release starts at FU 0.

Configuration
REQ-025 Macro WBARB_PERF_EN: when defined, 32-bit saturating counters o_perf_stall_cycles (cycles with any o_wb_stall=1) and o_perf_wb_count (sum of grants) exist as outputs.
REQ-026 Without WBARB_PERF_EN the counter ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-027 comwbInfo_t, iprIdx_t and NUM_WBPORT default belong in the shared core package/define header, not this module.
REQ-028 One sub-module rr_picker (round-robin first-K selector: request vector + pointer -> grant vector + per-port index) is natural; the rest is inline.

Verification
REQ-029 NUM_FU=4, NUM_WBPORT=2, rr_ptr=0, finished=4'b1111 -> grant FU0,FU1; stall=4'b1100; next cycle o_wb_vld=2'b11, rr_ptr=2.
REQ-030 Hold finished=4'b1111 for 2 cycles -> cycle 2 grants FU2,FU3; all four results written exactly once over 2 cycles.
REQ-031 finished=4'b0100, rd_wen=1, iprd_idx=9, result=0x55 -> o_bypass_vld[0]=1 same cycle, o_rf_wen=2'b01 next cycle with result 0x55.
REQ-032 i_wb_block=1 with finished=4'b0011 -> stall=4'b0011, no bypass, o_wb_vld=0 next cycle, rr_ptr unchanged.
REQ-033 rst=0 for one cycle while o_wb_vld=2'b11 -> o_wb_vld=0 next cycle; first post-reset grant starts at FU0.
REQ-034 WBARB_PERF_EN defined, 10 cycles of 4 finished/2 ports -> o_perf_wb_count=20, o_perf_stall_cycles=10.
